// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS Harvard memory responder.
// - run_state_t: responder run/halt state, encoded as seen on the run_state port.
// - Fault* : bit positions inside the sticky fault vector.
// - Default window bases and the fill word returned by rejected data reads.
// - sat_inc16: 16-bit saturating increment used by the traffic counters.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StHalted = 2'd2
  } run_state_t;

  localparam int unsigned FaultInstr     = 0;  // fetch out of window or unaligned
  localparam int unsigned FaultDataWin   = 1;  // data access out of window
  localparam int unsigned FaultDataAlign = 2;  // data access unaligned
  localparam int unsigned FaultRdWr      = 3;  // read and write strobes together

  localparam logic [31:0] DefaultInstrBase = 32'hBFC00000;
  localparam logic [31:0] DefaultDataBase  = 32'h00001000;
  localparam logic [31:0] DataFill         = 32'hDEADBEEF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mips_word_ram.sv
// Word-wide memory array: one synchronous write port, one asynchronous read port.
// Contents are not reset.
// Ports:
//   clk_i    clock
//   we_i     write enable (sampled on posedge clk_i)
//   waddr_i  write word index
//   wdata_i  write data
//   raddr_i  read word index
//   rdata_o  read data (combinational)
module mips_word_ram #(
  parameter int unsigned Words = 256,
  parameter int unsigned AddrW = $clog2(Words)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [Words];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mips_harvard_mem_responder.sv
// Memory-side responder for the mips_cpu_harvard bus pair: instruction ROM window with
// combinational fetch, data RAM window with combinational read and single-cycle write,
// IDLE/RUN/HALTED tracking from the CPU active flag, saturating traffic counters and
// sticky protocol faults. Arrays are filled by the preload port while IDLE.
// Optional build macro: STALL_INJECT_EN (periodic one-cycle clk_enable stall in RUN).
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   active / clk_enable       CPU run flag in, CPU clock enable out
//   instr_address/readdata    fetch bus
//   data_address/write/read/writedata/readdata   data bus
//   load_en/sel/index/data    preload port (IDLE only; sel 0 = ROM, 1 = RAM)
//   run_state, done           0 IDLE / 1 RUN / 2 HALTED, one-cycle pulse on RUN->HALTED
//   read_count, write_count   saturating accepted-read / committed-write counters
//   fault                     sticky fault flags, recorded only in RUN
module mips_harvard_mem_responder
  import mips_mem_pkg::*;
#(
  parameter logic [31:0] INSTR_BASE   = DefaultInstrBase,
  parameter int unsigned INSTR_WORDS  = 256,
  parameter logic [31:0] DATA_BASE    = DefaultDataBase,
  parameter int unsigned DATA_WORDS   = 1024,
  parameter int unsigned STALL_PERIOD = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        active,
  output logic        clk_enable,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic [31:0] data_address,
  input  logic        data_write,
  input  logic        data_read,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  input  logic        load_en,
  input  logic        load_sel,
  input  logic [15:0] load_index,
  input  logic [31:0] load_data,
  output logic [1:0]  run_state,
  output logic        done,
  output logic [15:0] read_count,
  output logic [15:0] write_count,
  output logic [3:0]  fault
);

  localparam int unsigned IAw       = $clog2(INSTR_WORDS);
  localparam int unsigned DAw       = $clog2(DATA_WORDS);
  localparam logic [31:0] InstrSpan = 32'(INSTR_WORDS) << 2;
  localparam logic [31:0] DataSpan  = 32'(DATA_WORDS) << 2;

  if (STALL_PERIOD < 2) begin : g_bad_period
    $error("STALL_PERIOD must be at least 2");
  end
  if ((INSTR_WORDS & (INSTR_WORDS - 1)) != 0 || (DATA_WORDS & (DATA_WORDS - 1)) != 0)
  begin : g_bad_depth
    $error("INSTR_WORDS and DATA_WORDS must be powers of 2");
  end

  run_state_t  state_q, state_d;
  logic        done_q, done_d;
  logic [15:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [3:0]  fault_q, fault_d;

  // Address decode: unsigned offset below the span covers both ends of the window.
  logic [31:0]    i_off, d_off;
  logic           i_ok, d_in_win, d_aligned, d_ok, d_access;
  logic [IAw-1:0] i_idx;
  logic [DAw-1:0] d_idx;

  assign i_off     = instr_address - INSTR_BASE;
  assign d_off     = data_address - DATA_BASE;
  assign i_ok      = (i_off < InstrSpan) && (i_off[1:0] == 2'b00);
  assign d_in_win  = d_off < DataSpan;
  assign d_aligned = d_off[1:0] == 2'b00;
  assign d_ok      = d_in_win && d_aligned;
  assign d_access  = data_read || data_write;
  assign i_idx     = IAw'(i_off >> 2);
  assign d_idx     = DAw'(d_off >> 2);

  // Preload has the RAM write port to itself while it is active.
  logic pre_rom, pre_ram, cpu_wr, cpu_rd;
  assign pre_rom = (state_q == StIdle) && load_en && !load_sel;
  assign pre_ram = (state_q == StIdle) && load_en && load_sel;
  assign cpu_wr  = data_write && !data_read && clk_enable && d_ok && !pre_ram;
  assign cpu_rd  = data_read && !data_write && clk_enable && d_ok;

  logic [31:0] rom_rdata, ram_rdata;

  mips_word_ram #(
    .Words (INSTR_WORDS)
  ) u_rom (
    .clk_i   (clk),
    .we_i    (pre_rom),
    .waddr_i (IAw'(load_index)),
    .wdata_i (load_data),
    .raddr_i (i_idx),
    .rdata_o (rom_rdata)
  );

  mips_word_ram #(
    .Words (DATA_WORDS)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (pre_ram || cpu_wr),
    .waddr_i (pre_ram ? DAw'(load_index) : d_idx),
    .wdata_i (pre_ram ? load_data : data_writedata),
    .raddr_i (d_idx),
    .rdata_o (ram_rdata)
  );

  assign instr_readdata = i_ok ? rom_rdata : 32'h00000000;
  assign data_readdata  = (data_read && d_ok) ? ram_rdata : DataFill;

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    fault_d  = fault_q;

    case (state_q)
      StIdle:   if (active) state_d = StRun;
      StRun: begin
        if (!active) begin
          state_d = StHalted;
          done_d  = 1'b1;
        end
      end
      StHalted: state_d = StHalted;
      default:  state_d = StIdle;
    endcase

    if (cpu_rd) rd_cnt_d = sat_inc16(rd_cnt_q);
    if (cpu_wr) wr_cnt_d = sat_inc16(wr_cnt_q);

    if (state_q == StRun) begin
      fault_d[FaultInstr]     = fault_q[FaultInstr] | ~i_ok;
      fault_d[FaultDataWin]   = fault_q[FaultDataWin] | (d_access & ~d_in_win);
      fault_d[FaultDataAlign] = fault_q[FaultDataAlign] | (d_access & ~d_aligned);
      fault_d[FaultRdWr]      = fault_q[FaultRdWr] | (data_read & data_write);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      done_q   <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      fault_q  <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      fault_q  <= fault_d;
    end
  end

`ifdef STALL_INJECT_EN
  localparam int unsigned Sw        = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
  localparam logic [Sw-1:0] StallAt = Sw'(STALL_PERIOD - 1);

  // Counts every RUN cycle; the last count of each period is the stall cycle.
  logic [Sw-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == StRun) begin
      stall_d = (stall_q == StallAt) ? '0 : stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign clk_enable = !((state_q == StRun) && (stall_q == StallAt));
`else
  assign clk_enable = 1'b1;
`endif

  assign run_state   = state_q;
  assign done        = done_q;
  assign read_count  = rd_cnt_q;
  assign write_count = wr_cnt_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_mips_harvard_mem_responder.sv
module tb_mips_harvard_mem_responder;

  localparam logic [31:0] IBase = 32'hBFC00000;
  localparam int          IWords = 256;
  localparam logic [31:0] DBase = 32'h00001000;
  localparam int          DWords = 1024;
  localparam int          Sp = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        active, clk_enable;
  logic [31:0] instr_address, instr_readdata;
  logic [31:0] data_address, data_writedata, data_readdata;
  logic        data_write, data_read;
  logic        load_en, load_sel;
  logic [15:0] load_index;
  logic [31:0] load_data;
  logic [1:0]  run_state;
  logic        done;
  logic [15:0] read_count, write_count;
  logic [3:0]  fault;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mips_harvard_mem_responder #(
    .INSTR_BASE   (IBase),
    .INSTR_WORDS  (IWords),
    .DATA_BASE    (DBase),
    .DATA_WORDS   (DWords),
    .STALL_PERIOD (Sp)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .active         (active),
    .clk_enable     (clk_enable),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .data_address   (data_address),
    .data_write     (data_write),
    .data_read      (data_read),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata),
    .load_en        (load_en),
    .load_sel       (load_sel),
    .load_index     (load_index),
    .load_data      (load_data),
    .run_state      (run_state),
    .done           (done),
    .read_count     (read_count),
    .write_count    (write_count),
    .fault          (fault)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_state = 0;   // 0 idle, 1 run, 2 halted
  bit          m_done = 0;
  int          m_rc = 0, m_wc = 0, m_runcyc = 0;
  logic [3:0]  m_fault = 4'h0;
  logic [31:0] rom_m [IWords];
  bit          rom_v [IWords];
  logic [31:0] ram_m [DWords];
  bit          ram_v [DWords];

  function automatic bit in_win(input logic [31:0] a, input logic [31:0] base, input int words);
    longint x, b;
    x = longint'({32'd0, a});
    b = longint'({32'd0, base});
    return (x >= b) && (x < b + 4 * longint'(words));
  endfunction

  function automatic int widx(input logic [31:0] a, input logic [31:0] base);
    return int'((longint'({32'd0, a}) - longint'({32'd0, base})) / 4);
  endfunction

  function automatic bit d_good(input logic [31:0] a);
    return in_win(a, DBase, DWords) && (a % 4 == 0);
  endfunction

  function automatic bit exp_ce();
`ifdef STALL_INJECT_EN
    return !(m_state == 1 && (m_runcyc % Sp) == Sp - 1);
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_state  <= 0;
      m_done   <= 0;
      m_rc     <= 0;
      m_wc     <= 0;
      m_fault  <= 4'h0;
      m_runcyc <= 0;
    end else begin
      m_done <= (m_state == 1) && !active;
      if (m_state == 0 && active) m_state <= 1;
      else if (m_state == 1 && !active) m_state <= 2;
      if (m_state == 1) m_runcyc <= m_runcyc + 1;
      if (m_state == 0 && load_en) begin
        if (load_sel) begin
          ram_m[int'(load_index) % DWords] <= load_data;
          ram_v[int'(load_index) % DWords] <= 1'b1;
        end else begin
          rom_m[int'(load_index) % IWords] <= load_data;
          rom_v[int'(load_index) % IWords] <= 1'b1;
        end
      end
      if (data_write && !data_read && exp_ce() && d_good(data_address) &&
          !(m_state == 0 && load_en && load_sel)) begin
        ram_m[widx(data_address, DBase)] <= data_writedata;
        ram_v[widx(data_address, DBase)] <= 1'b1;
        if (m_wc < 65535) m_wc <= m_wc + 1;
      end
      if (data_read && !data_write && exp_ce() && d_good(data_address)) begin
        if (m_rc < 65535) m_rc <= m_rc + 1;
      end
      if (m_state == 1) begin
        m_fault <= m_fault | {data_read && data_write,
                              (data_read || data_write) && (data_address % 4 != 0),
                              (data_read || data_write) && !in_win(data_address, DBase, DWords),
                              !(in_win(instr_address, IBase, IWords) && instr_address % 4 == 0)};
      end
    end
  end

  // Compare every cycle on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("run_state", 32'(run_state), 32'(m_state));
      chk("done", 32'(done), 32'(m_done));
      chk("read_count", 32'(read_count), 32'(m_rc));
      chk("write_count", 32'(write_count), 32'(m_wc));
      chk("fault", 32'(fault), 32'(m_fault));
      chk("clk_enable", 32'(clk_enable), 32'(exp_ce()));
      if (in_win(instr_address, IBase, IWords) && instr_address % 4 == 0) begin
        if (rom_v[widx(instr_address, IBase)])
          chk("instr_readdata", instr_readdata, rom_m[widx(instr_address, IBase)]);
      end else begin
        chk("instr_readdata_oow", instr_readdata, 32'h0);
      end
      if (data_read && d_good(data_address)) begin
        if (ram_v[widx(data_address, DBase)])
          chk("data_readdata", data_readdata, ram_m[widx(data_address, DBase)]);
      end else begin
        chk("data_readdata_fill", data_readdata, 32'hDEADBEEF);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    data_read = 1'b0;
    data_write = 1'b0;
    data_address = DBase;
    data_writedata = 32'h0;
    load_en = 1'b0;
  endtask

  task automatic preload(input logic sel, input logic [15:0] idx, input logic [31:0] d);
    load_en = 1'b1;
    load_sel = sel;
    load_index = idx;
    load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic pulse_reset_and_check();
    reset_n = 1'b0;
    #2;
    chk("rst_run_state", 32'(run_state), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_read_count", 32'(read_count), 32'd0);
    chk("rst_write_count", 32'(write_count), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_clk_enable", 32'(clk_enable), 32'd1);
    reset_n = 1'b1;
  endtask

`ifdef STALL_INJECT_EN
  task automatic stall_scenario();
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        data_write = 1'b1;
        data_address = 32'h00001010;
        data_writedata = 32'h00000005;
      end else begin
        data_write = 1'b0;
      end
      #1;
      chk("stall_pattern", 32'(clk_enable), (i % 4 == 3) ? 32'd0 : 32'd1);
      tick();
    end
    data_write = 1'b0;
    chk("stall_write_count", 32'(write_count), 32'd0);
    data_read = 1'b1;
    data_address = 32'h00001010;
    #1;
    chk("stall_write_dropped", data_readdata, 32'h12345678);
    tick();
    data_read = 1'b0;
  endtask
`else
  task automatic main_scenario();
    data_write = 1'b1;
    data_address = 32'h00001004;
    data_writedata = 32'hF0000000;
    tick();
    data_write = 1'b0;
    data_read = 1'b1;
    #1;
    chk("raw_readback", data_readdata, 32'hF0000000);
    tick();
    chk("wc_after_write", 32'(write_count), 32'd1);
    chk("rc_after_read", 32'(read_count), 32'd1);
    data_address = 32'h00001008;
    #1;
    chk("preload_index_mod", data_readdata, 32'hCAFEF00D);
    tick();
    data_read = 1'b0;
    // last word of the data window
    data_write = 1'b1;
    data_address = 32'h00001FFC;
    data_writedata = 32'hA5A5A5A5;
    tick();
    data_write = 1'b0;
    data_read = 1'b1;
    #1;
    chk("last_word", data_readdata, 32'hA5A5A5A5);
    tick();
    data_read = 1'b0;
    instr_address = 32'hBFC00004;
    #1;
    chk("fetch_word1", instr_readdata, 32'h8C220004);
    tick();
    instr_address = IBase;
    // read and write together
    data_read = 1'b1;
    data_write = 1'b1;
    data_address = 32'h00001000;
    data_writedata = 32'hAAAAAAAA;
    tick();
    data_write = 1'b0;
    #1;
    chk("rdwr_no_write", data_readdata, 32'h11111111);
    chk("rdwr_fault", 32'(fault), 32'h8);
    chk("rdwr_wc", 32'(write_count), 32'd2);
    chk("rdwr_rc", 32'(read_count), 32'd3);
    tick();
    data_read = 1'b0;
    // fresh run for window/alignment faults
    pulse_reset_and_check();
    tick();
    chk("rerun_state", 32'(run_state), 32'd1);
    data_read = 1'b1;
    data_address = 32'h00000FFC;
    #1;
    chk("below_window_fill", data_readdata, 32'hDEADBEEF);
    tick();
    data_read = 1'b0;
    data_write = 1'b1;
    data_address = 32'h00001002;
    data_writedata = 32'h77777777;
    tick();
    data_write = 1'b0;
    #1;
    chk("win_align_fault", 32'(fault), 32'h6);
    chk("fault_rc", 32'(read_count), 32'd0);
    chk("fault_wc", 32'(write_count), 32'd0);
    instr_address = 32'hBFC00400;
    #1;
    chk("fetch_past_window", instr_readdata, 32'h0);
    instr_address = 32'hBFC00002;
    #1;
    chk("fetch_unaligned", instr_readdata, 32'h0);
    tick();
    instr_address = IBase;
    #1;
    chk("instr_fault", 32'(fault), 32'h7);
  endtask
`endif

  initial begin
    active = 1'b0;
    instr_address = IBase;
    load_sel = 1'b0;
    load_index = 16'h0;
    load_data = 32'h0;
    bus_idle();
    #12;
    chk("init_run_state", 32'(run_state), 32'd0);
    chk("init_fault", 32'(fault), 32'd0);
    chk("init_clk_enable", 32'(clk_enable), 32'd1);
    reset_n = 1'b1;
    tick();

    preload(1'b0, 16'd0, 32'h24010020);
    preload(1'b0, 16'd1, 32'h8C220004);
    preload(1'b1, 16'd1026, 32'hCAFEF00D);
    preload(1'b1, 16'd0, 32'h11111111);
    preload(1'b1, 16'd4, 32'h12345678);
    #1;
    chk("idle_fetch", instr_readdata, 32'h24010020);

    active = 1'b1;
    tick();
    chk("run_state_run", 32'(run_state), 32'd1);
    chk("reset_vector_fetch", instr_readdata, 32'h24010020);

`ifdef STALL_INJECT_EN
    stall_scenario();
`else
    main_scenario();
`endif

    bus_idle();
    active = 1'b0;
    tick();
    chk("done_pulse", 32'(done), 32'd1);
    chk("halted", 32'(run_state), 32'd2);
    tick();
    chk("done_cleared", 32'(done), 32'd0);
    preload(1'b0, 16'd0, 32'hFFFFFFFF);
    #1;
    chk("halted_preload_ignored", instr_readdata, 32'h24010020);
    chk("still_halted", 32'(run_state), 32'd2);
    tick();
    pulse_reset_and_check();
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_harvard_mem_responder.md
Name: mips_harvard_mem_responder

Overview:
- Memory-side responder for the mips_cpu_harvard bus pair: serves combinational instruction fetch, combinational data reads and single-cycle data writes.
- Replaces hand-driven instr_readdata/data_readdata stimulus in CPU benches with a real instruction ROM window and data RAM.
- Tracks CPU run/halt through `active`, counts bus traffic and latches protocol faults.
- Synthesizable; sits beside the CPU in the top-level test harness.

Parameters:
- INSTR_BASE, 32'hBFC00000, byte base address of the instruction window (reset vector)
- INSTR_WORDS, 256, instruction ROM depth in 32-bit words (power of 2)
- DATA_BASE, 32'h00001000, byte base address of the data RAM window
- DATA_WORDS, 1024, data RAM depth in 32-bit words (power of 2)
- STALL_PERIOD, 4, cycles between injected stalls (used only with the optional feature)

Ports:
- clk in 1 system clock
- reset_n in 1 asynchronous active-low reset
- active in 1 CPU active flag
- clk_enable out 1 clock enable driven to the CPU
- instr_address in 32 CPU fetch address
- instr_readdata out 32 fetched word
- data_address in 32 CPU data address
- data_write in 1 write strobe
- data_read in 1 read strobe
- data_writedata in 32 write data
- data_readdata out 32 read data
- load_en in 1 preload strobe (honoured only in IDLE)
- load_sel in 1 preload target: 0 instruction ROM, 1 data RAM
- load_index in 16 preload word index
- load_data in 32 preload word
- run_state out 2 0 IDLE, 1 RUN, 2 HALTED
- done out 1 one-cycle pulse on RUN->HALTED
- read_count out 16 saturating count of accepted data reads
- write_count out 16 saturating count of committed data writes
- fault out 4 sticky: [0] instr out-of-window/unaligned, [1] data out-of-window, [2] data unaligned, [3] read and write asserted together

Behaviour:
- Reset is asynchronous and active-low; one clock. Asserting reset_n low at any time: run_state=IDLE, done=0, counters=0, fault=0, stall counter=0, clk_enable=1. RAM/ROM contents are not reset.
- Decode: word index = (addr - base) >> 2; in window iff 0 <= addr - base < 4*WORDS.
- instr_readdata, combinational: ROM word when instr_address is in the window and addr[1:0]==0, else 32'h00000000. Any other fetch sets fault[0] at the next posedge, but only in RUN.
- data_readdata, combinational: RAM word when data_read=1 and the address is in the window and aligned, else 32'hDEADBEEF.
- Write: committed at posedge when data_write=1, data_read=0, clk_enable=1, address in window and aligned. Read-after-write to the same word returns the new value from the following cycle.
- data_read && data_write together: no write, fault[3] set, neither counter increments.
- Out-of-window data access sets fault[1]; misaligned access sets fault[2]. Faulting writes are dropped.
- Counters increment on qualified accesses (clk_enable=1, no fault) and saturate at 16'hFFFF.
- FSM:
  - IDLE -> RUN when active=1.
  - RUN -> HALTED when active=0; done pulses for one cycle on this transition.
  - HALTED is terminal until reset.
- Preload: load_en in IDLE writes load_data to the selected array at load_index mod WORDS on posedge. Ignored in RUN/HALTED (no fault).
- Faults are sticky until reset and are recorded only in RUN.

Optional Feature:
- STALL_INJECT_EN defined: in RUN, clk_enable is driven 0 for exactly one cycle after every STALL_PERIOD-1 enabled cycles. Writes and counters are gated while clk_enable=0. The stall counter is held in IDLE/HALTED.
- Undefined: clk_enable is constant 1 and the stall counter is not instantiated.

Decomposition:
- Shared package mips_mem_pkg: run_state_t enum (IDLE/RUN/HALTED), fault bit index constants, default base addresses, DEADBEEF fill constant.
- One sub-module, mips_word_ram: parameterized single-write-port, async-read word array. Instantiated twice; the ROM instance is written only by preload.

Test Plan:
- Preload ROM[0]=32'h24010020, then release with active=1 -> instr_address 32'hBFC00000 reads 32'h24010020; run_state=1.
- Write 32'hF0000000 to 32'h00001004, read the same address next cycle -> data_readdata=32'hF0000000; write_count=1, read_count=1.
- data_read=data_write=1 at 32'h00001000 -> RAM word unchanged; fault=4'b1000; counters unchanged.
- Read 32'h00000FFC and write 32'h00001002 -> data_readdata=32'hDEADBEEF; fault=4'b0110.
- active drops -> done high for exactly one cycle; run_state=2; a later load_en has no effect; reset_n pulse -> all outputs at reset values.
- With STALL_INJECT_EN and STALL_PERIOD=4 -> clk_enable pattern 1,1,1,0 repeating; a write presented in the stall cycle is not committed and write_count does not increment.
